// File: rtl/vcve2_vec_ex_seq.sv
// Multi-beat vector integer execute unit: one 32-bit beat per cycle over a VLEN-wide operation.
// Optional per-element masking by v0 is enabled with macro VCVE2_VEC_MASK_EN.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready_o high
//   BUSY  | processing beat beat_q of the latched request
//   DONE  | result held with out_valid_o high until consumed or killed
module vcve2_vec_ex_seq #(
    parameter int VLEN = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [2:0]                   op_i,
    input  logic [2:0]                   vsew_i,
    input  logic [$clog2(VLEN/8):0]      vl_i,
    input  logic [VLEN-1:0]              vs2_i,
    input  logic [VLEN-1:0]              vs1_i,
    input  logic [31:0]                  scalar_i,
    input  logic                         use_scalar_i,
    input  logic [VLEN-1:0]              vd_old_i,
    input  logic [VLEN/8-1:0]            v0_mask_i,
    input  logic                         kill_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [VLEN-1:0]              result_o,
    output logic                         busy_o,
    output logic                         illegal_o
);
    localparam int NBEATS = VLEN / 32;
    localparam int VLW    = $clog2(VLEN / 8) + 1;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [BW-1:0]     beat_q;
    logic [2:0]        op_q;
    logic [2:0]        vsew_q;
    logic [VLW-1:0]    vl_q;
    logic [VLEN-1:0]   vs2_q;
    logic [VLEN-1:0]   vs1_q;
    logic [31:0]       scalar_q;
    logic              use_scalar_q;
    logic [VLEN-1:0]   vd_old_q;
    logic [VLEN-1:0]   result_q;
    logic              out_valid_q;
    logic              illegal_q;
`ifdef VCVE2_VEC_MASK_EN
    logic [VLEN/8-1:0] mask_q;
    logic [VLEN/8-1:0] mask_sh;
`else
    logic              unused_mask;
    assign unused_mask = ^v0_mask_i;
`endif

    logic [31:0] off;
    logic [31:0] a_w, b_w, old_w, ob, r, e, word_new;
    logic [1:0]  lanes_sh;
    logic [3:0]  act_v;
    logic        legal;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return b;
        endcase
    endfunction

    always_comb begin
        off      = 32'(beat_q) << 5;
        a_w      = 32'(vs2_q >> off);
        b_w      = 32'(vs1_q >> off);
        old_w    = 32'(vd_old_q >> off);
        legal    = (op_q < 3'd6) && (vsew_q < 3'd3);
        word_new = old_w;
        ob       = b_w;
        r        = '0;
        e        = '0;
        act_v    = '0;
`ifdef VCVE2_VEC_MASK_EN
        mask_sh  = '0;
`endif
        case (vsew_q)
            3'd0:    lanes_sh = 2'd2;
            3'd1:    lanes_sh = 2'd1;
            default: lanes_sh = 2'd0;
        endcase
        // Element index of lane k; lanes beyond 32/SEW are never consumed.
        for (int k = 0; k < 4; k++) begin
            e        = (32'(beat_q) << lanes_sh) + 32'(k);
            act_v[k] = legal && (e < 32'(vl_q));
`ifdef VCVE2_VEC_MASK_EN
            mask_sh  = mask_q >> e;
            act_v[k] = act_v[k] && mask_sh[0];
`endif
        end
        case (vsew_q)
            3'd0: begin
                if (use_scalar_q) ob = {4{scalar_q[7:0]}};
                for (int k = 0; k < 4; k++) begin
                    r = alu(op_q, {24'b0, a_w[8*k +: 8]}, {24'b0, ob[8*k +: 8]});
                    if (act_v[k]) word_new[8*k +: 8] = r[7:0];
                end
            end
            3'd1: begin
                if (use_scalar_q) ob = {2{scalar_q[15:0]}};
                for (int k = 0; k < 2; k++) begin
                    r = alu(op_q, {16'b0, a_w[16*k +: 16]}, {16'b0, ob[16*k +: 16]});
                    if (act_v[k]) word_new[16*k +: 16] = r[15:0];
                end
            end
            3'd2: begin
                if (use_scalar_q) ob = scalar_q;
                r = alu(op_q, a_w, ob);
                if (act_v[0]) word_new = r;
            end
            default: word_new = old_w;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            op_q         <= '0;
            vsew_q       <= '0;
            vl_q         <= '0;
            vs2_q        <= '0;
            vs1_q        <= '0;
            scalar_q     <= '0;
            use_scalar_q <= 1'b0;
            vd_old_q     <= '0;
            result_q     <= '0;
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef VCVE2_VEC_MASK_EN
            mask_q       <= '0;
`endif
        end else if (kill_i && state_q != IDLE) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    op_q         <= op_i;
                    vsew_q       <= vsew_i;
                    vl_q         <= vl_i;
                    vs2_q        <= vs2_i;
                    vs1_q        <= vs1_i;
                    scalar_q     <= scalar_i;
                    use_scalar_q <= use_scalar_i;
                    vd_old_q     <= vd_old_i;
`ifdef VCVE2_VEC_MASK_EN
                    mask_q       <= v0_mask_i;
`endif
                    beat_q       <= '0;
                    state_q      <= BUSY;
                end
                BUSY: begin
                    for (int w = 0; w < NBEATS; w++)
                        if (beat_q == BW'(w)) result_q[w*32 +: 32] <= word_new;
                    if (beat_q == BW'(NBEATS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        illegal_q   <= ~legal;
                        beat_q      <= '0;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                DONE: if (out_ready_i) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    illegal_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign illegal_o   = illegal_q;
endmodule

// File: doc/vcve2_vec_ex_seq.md
VCVE2_VEC_EX_SEQ -- requirements
Module: vcve2_vec_ex_seq

Interface
REQ-001 The block SHALL have parameter VLEN, default 128, giving the vector register width in bits; legal values are multiples of 32 and at least 32.
REQ-002 The block SHALL have parameter NBEATS, fixed as VLEN/32, giving the number of 32-bit beats per operation; it is not overridable.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
  - clk_i  in  1  clock.
  - rst_ni  in  1  asynchronous active-low reset.
  - in_valid_i  in  1  operation request.
  - in_ready_o  out  1  request accepted when high together with in_valid_i.
  - op_i  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MV; 6 and 7 are illegal.
  - vsew_i  in  3  element width: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit; other values are illegal.
  - vl_i  in  $clog2(VLEN/8)+1  active element count.
  - vs2_i  in  VLEN  operand A.
  - vs1_i  in  VLEN  operand B, vector form.
  - scalar_i  in  32  operand B, scalar form.
  - use_scalar_i  in  1  selects scalar_i splatted at SEW as operand B.
  - vd_old_i  in  VLEN  prior destination value, used for tail, masked and illegal elements.
  - v0_mask_i  in  VLEN/8  per-element mask, where bit e belongs to element e.
  - kill_i  in  1  synchronous abort.
  - out_valid_o  out  1  result valid.
  - out_ready_i  in  1  consumer ready.
  - result_o  out  VLEN  result vector.
  - busy_o  out  1  high in any state other than IDLE.
  - illegal_o  out  1  illegal op_i or vsew_i in the latched request; valid with out_valid_o.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready_o is high only in IDLE.
REQ-005 On an in_valid_i && in_ready_o edge, the block SHALL latch all request inputs, clear the beat counter to 0 and enter BUSY.
REQ-006 In BUSY, the block SHALL process 32-bit word b (bits 32b+31..32b) each cycle, write it into the result register, and increment b.
REQ-007 After beat NBEATS-1, the block SHALL enter DONE; out_valid_o therefore rises exactly NBEATS cycles after the accept edge.
REQ-008 In DONE, out_valid_o SHALL be high and result_o stable until out_valid_o && out_ready_i, after which the block returns to IDLE; there is no same-cycle re-accept.
REQ-009 Per element, the block SHALL compute ADD vs2+opB, SUB vs2-opB, AND/OR/XOR bitwise, and MV opB, modulo 2^SEW with no carry or borrow across elements.
REQ-010 Operand B (opB) SHALL be the SEW-wide element of vs1_i, or, when use_scalar_i=1, scalar_i[SEW-1:0] replicated across the word.
REQ-011 The element index SHALL be e = b*(32/SEW)+k for lane k of beat b; the element is active iff e < vl_i (and the mask condition of REQ-017 holds when enabled).
REQ-012 Inactive elements SHALL take the corresponding bits of vd_old_i (tail- and mask-undisturbed).
REQ-013 A vl_i value of 0 SHALL yield result_o equal to vd_old_i; vl_i greater than VLEN/SEW SHALL behave as VLEN/SEW.
REQ-014 An illegal op_i or vsew_i SHALL still take NBEATS beats, produce result_o equal to vd_old_i, and set illegal_o=1 in DONE.
REQ-015 kill_i in BUSY or DONE SHALL force IDLE on the next edge with out_valid_o=0; kill_i has priority over out_ready_i, and kill_i in IDLE is ignored.

Reset
REQ-016 On reset the block SHALL enter IDLE with beat counter=0, result_o=0, out_valid_o=0, illegal_o=0 and busy_o=0, aborting any operation in flight; in_ready_o is 1 once reset is released.

Configuration
REQ-017 When macro VCVE2_VEC_MASK_EN is defined, an element SHALL be active only if it also has v0_mask_i[e]=1.
REQ-018 When VCVE2_VEC_MASK_EN is not defined, v0_mask_i SHALL be ignored and all elements with e < vl_i are active.

Verification (VLEN=128)
REQ-019 SEW8 ADD test: vl=16, vs2 bytes 0x01, vs1 bytes 0xFF -> result all 0x00, out_valid_o 4 cycles after accept, illegal_o=0.
REQ-020 SEW16 SUB tail test: vl=3, vs2=0x0005 per element, vs1=0x0007 per element, vd_old=all 0xAAAA -> elements 0..2 = 0xFFFE, elements 3..7 = 0xAAAA.
REQ-021 SEW32 MV splat test: use_scalar=1, scalar=0x12345678, vl=4 -> result = four words of 0x12345678.
REQ-022 Mask test: SEW32 ADD, vl=4, v0_mask=0b0101, vd_old=0xDEADBEEF per element -> with macro, elements 1 and 3 = 0xDEADBEEF; without macro, all four elements are computed.
REQ-023 Kill test: kill_i at beat 2 -> IDLE and in_ready_o=1 next cycle, with no out_valid_o pulse.
REQ-024 Backpressure and illegal test: out_ready_i held low 5 cycles in DONE -> result_o stable and in_ready_o=0; separately, vsew=3 -> illegal_o=1 and result = vd_old.
